// File: rtl/irrigacao_pkg.sv
// irrigacao_pkg: shared state encodings and 7-segment glyphs for the zone irrigation controller.
package irrigacao_pkg;
  typedef enum logic [1:0] {OCIOSO, REGANDO, PAUSA} estado_t;
  typedef enum logic {FECHADA, ABERTA} valvula_t;
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_G     = 7'h5E;
  localparam logic [6:0] SEG_TRACO = 7'h01;
endpackage

// File: rtl/filtro_persistencia.sv
// filtro_persistencia: output follows the input only after N consecutive samples of the new value.
module filtro_persistencia #(
  parameter int N = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  localparam int CW = $clog2(N + 1);
  logic [CW-1:0] r_cnt;
  logic          r_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (i_d == r_q) r_cnt <= '0;
    else if (r_cnt == CW'(N - 1)) begin
      r_q   <= i_d;
      r_cnt <= '0;
    end else r_cnt <= r_cnt + 1'b1;
  assign o_q = r_q;
endmodule

// File: rtl/controlador_irrigacao_zonas.sv
// controlador_irrigacao_zonas: round-robin multi-zone irrigation scheduler with tank supervision and display.
module controlador_irrigacao_zonas
  import irrigacao_pkg::*;
#(
  parameter int NUM_ZONAS   = 4,
  parameter int TEMPO_MIN   = 16,
  parameter int TEMPO_MAX   = 256,
  parameter int TEMPO_PAUSA = 8,
  parameter int FILTRO_ERRO = 4
) (
  input  logic                         Clock,
  input  logic                         Reset_n,
  input  logic                         UmidadeAr,
  input  logic                         Temperatura,
  input  logic [NUM_ZONAS-1:0]         UmidadeSolo,
  input  logic                         High,
  input  logic                         Medium,
  input  logic                         Low,
  input  logic                         ChaveSeletora,
  output logic [NUM_ZONAS-1:0]         Gotejamento,
  output logic [NUM_ZONAS-1:0]         Aspersao,
  output logic [$clog2(NUM_ZONAS)-1:0] ZonaAtiva,
  output logic                         Erro,
  output logic                         Alarme,
  output logic                         ValvulaEntrada,
  output logic [6:0]                   Segmentos
);
  localparam int ZW = $clog2(NUM_ZONAS);
  localparam int CW = $clog2(TEMPO_MAX);
  localparam int SW = NUM_ZONAS + 6;
  logic [SW-1:0]        r_s1, r_s2;
  logic                 w_sel, w_ar, w_temp, w_h, w_m, w_l, w_erro, w_asp, w_achou, w_fim;
  logic [NUM_ZONAS-1:0] w_solo, w_onehot;
  logic [ZW-1:0]        w_idx, w_escolha, r_zona, r_ptr;
  logic [CW-1:0]        r_cnt;
  logic                 r_alarme, r_modo;
  logic [6:0]           r_seg;
  estado_t              r_estado;
  valvula_t             r_valv;
  assign {w_sel, w_ar, w_temp, w_h, w_m, w_l, w_solo} = r_s2;
  filtro_persistencia #(.N(FILTRO_ERRO)) u_filtro (
    .i_clk  (Clock),
    .i_rst_n(Reset_n),
    .i_d    ((w_h & ~w_m) | (w_m & ~w_l)),
    .o_q    (w_erro)
  );
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_alarme <= 1'b0;
      r_valv   <= FECHADA;
      r_seg    <= '0;
    end else begin
      r_s1     <= {ChaveSeletora, UmidadeAr, Temperatura, High, Medium, Low, UmidadeSolo};
      r_s2     <= r_s1;
      r_alarme <= ~w_l | w_erro;
      r_valv   <= (r_valv == FECHADA) ? ((~w_m & ~w_h & ~w_erro) ? ABERTA : FECHADA)
                                      : ((w_h | w_erro) ? FECHADA : ABERTA);
      r_seg    <= w_sel ? ((r_estado == REGANDO) ? (r_modo ? SEG_A : SEG_G) : SEG_TRACO)
                        : (w_erro ? SEG_E : (w_h & w_m & w_l) ? SEG_3 : (w_m & w_l) ? SEG_2 : w_l ? SEG_1 : SEG_0);
    end
  // Descending scan so the lowest offset from the pointer wins.
  always_comb begin
    w_idx     = '0;
    w_escolha = '0;
    for (int k = NUM_ZONAS - 1; k >= 0; k--) begin
      w_idx = ZW'((int'(r_ptr) + k) % NUM_ZONAS);
      if (~w_solo[w_idx]) w_escolha = w_idx;
    end
  end
  assign w_achou = ~&w_solo;
  assign w_asp   = ~w_ar | (w_m & ~w_temp);
  assign w_fim   = r_alarme | (r_cnt == CW'(TEMPO_MAX - 1)) | ((r_cnt >= CW'(TEMPO_MIN - 1)) & w_solo[r_zona]);
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      r_estado <= OCIOSO;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_zona   <= '0;
      r_modo   <= 1'b0;
    end else
      case (r_estado)
        OCIOSO:
          if (!r_alarme && w_achou) begin
            r_estado <= REGANDO;
            r_zona   <= w_escolha;
            r_modo   <= w_asp;
            r_cnt    <= '0;
          end
        REGANDO:
          if (w_fim) begin
            r_estado <= PAUSA;
            r_cnt    <= '0;
            r_ptr    <= (r_zona == ZW'(NUM_ZONAS - 1)) ? '0 : r_zona + 1'b1;
          end else r_cnt <= r_cnt + 1'b1;
        PAUSA:
          if (r_cnt == CW'(TEMPO_PAUSA - 1)) begin
            r_estado <= OCIOSO;
            r_cnt    <= '0;
          end else r_cnt <= r_cnt + 1'b1;
        default: r_estado <= OCIOSO;
      endcase
  assign w_onehot       = {{(NUM_ZONAS - 1){1'b0}}, 1'b1} << r_zona;
  assign Gotejamento    = (r_estado == REGANDO && !r_modo) ? w_onehot : '0;
  assign Aspersao       = (r_estado == REGANDO && r_modo) ? w_onehot : '0;
  assign ZonaAtiva      = r_zona;
  assign Erro           = w_erro;
  assign Alarme         = r_alarme;
  assign ValvulaEntrada = (r_valv == ABERTA);
  assign Segmentos      = r_seg;
endmodule
